// File: rtl/cic_pkg.sv
// Shared types for the CIC rate controller and its phase counter.
package cic_pkg;

  localparam int OSW_DEF = 3;

  typedef logic [OSW_DEF-1:0] os_sel_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_CLEAR,
    ST_SETTLE
  } cic_rate_state_e;

endpackage

// File: rtl/cic_phase_cnt.sv
// Decimation phase counter: counts in_valid, flags the frame's last sample, registers it as clk_div.
// Latency: terminal in_valid -> clk_div 1 cycle; clr zeroes the phase and swallows that cycle's sample.
// Backpressure: none, in_valid is consumed every cycle it is asserted.
module cic_phase_cnt
  import cic_pkg::*;
#(
  parameter int OSW = OSW_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  input  logic           clr,
  input  logic [OSW-1:0] os_sel,
  output logic           clk_div
);

  // Wide enough for the largest ratio, 2^(2^OSW-1), so every select value gets a full frame.
  localparam int CNTW = (1 << OSW) - 1;

  logic [CNTW-1:0] cnt;
  logic [CNTW-1:0] cnt_last;
  logic            term;

  assign cnt_last = {CNTW{1'b1}} >> (CNTW - int'(os_sel));
  assign term     = in_valid && !clr && (cnt == cnt_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      clk_div <= 1'b0;
    end else begin
      clk_div <= term;
      if (clr) begin
        cnt <= '0;
      end else if (in_valid) begin
        cnt <= term ? '0 : cnt + CNTW'(1);
      end
    end
  end

endmodule

// File: rtl/cic_rate_ctrl.sv
// Rate controller for cic_filter: decimation strobe plus frame-aligned os_sel changes (CIC_RATE_CTRL_SETTLE_EN adds output discard).
// Latency: clk_div 1 cycle after terminal in_valid; filt_clr 1 cycle after the last old-rate clk_div; new os_sel 1 cycle later.
// Backpressure: none; os_sel_wr is ignored while busy is high in CLEAR/SETTLE.
module cic_rate_ctrl
  import cic_pkg::*;
#(
  parameter int OSW      = OSW_DEF,
  parameter int OS_RESET = 1,
  parameter int SETTLE   = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  input  logic [OSW-1:0] os_sel_req,
  input  logic           os_sel_wr,
  output logic [OSW-1:0] os_sel,
  output logic           clk_div,
  output logic           filt_clr,
  output logic           out_valid,
  output logic           busy
);

`ifdef CIC_RATE_CTRL_SETTLE_EN
  localparam bit SETTLE_EN = 1'b1;
`else
  localparam bit SETTLE_EN = 1'b0;
`endif
  localparam int SETTLE_EFF = SETTLE_EN ? SETTLE : 0;

  cic_rate_state_e state;
  cic_rate_state_e state_nxt;
  logic [OSW-1:0]  os_sel_q;
  logic [OSW-1:0]  pend;
  logic            req_new;
  logic            drain_exit;
  logic            cnt_clr;

  assign req_new    = os_sel_wr && (os_sel_req != os_sel_q);
  assign drain_exit = (state == ST_DRAIN) && clk_div;
  // The drain exit cycle already belongs to the clear: counting its sample could
  // raise a stray old-rate strobe inside CLEAR, and CLEAR would zero it anyway.
  assign cnt_clr    = (state == ST_CLEAR) || drain_exit;

  cic_phase_cnt #(
    .OSW (OSW)
  ) u_phase_cnt (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .clr      (cnt_clr),
    .os_sel   (os_sel_q),
    .clk_div  (clk_div)
  );

`ifdef CIC_RATE_CTRL_SETTLE_EN
  localparam logic [3:0] SETTLE_LAST = 4'((SETTLE_EFF > 0) ? SETTLE_EFF - 1 : 0);
  logic [3:0] disc_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      disc_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      disc_cnt <= '0;
    end else if ((state == ST_SETTLE) && clk_div) begin
      disc_cnt <= disc_cnt + 4'd1;
    end
  end
`endif

  // A write coincident with a terminal count still passes through DRAIN for the
  // one cycle its strobe is in flight, so CLEAR always follows the final clk_div.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (req_new) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (clk_div) state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        state_nxt = (SETTLE_EFF == 0) ? ST_RUN : ST_SETTLE;
      end
      ST_SETTLE: begin
`ifdef CIC_RATE_CTRL_SETTLE_EN
        if (clk_div && (disc_cnt == SETTLE_LAST)) state_nxt = ST_RUN;
`else
        state_nxt = ST_RUN;
`endif
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_RUN;
      os_sel_q <= OSW'(OS_RESET);
      pend     <= OSW'(OS_RESET);
    end else begin
      state <= state_nxt;
      if (((state == ST_RUN) && req_new) || ((state == ST_DRAIN) && os_sel_wr)) begin
        pend <= os_sel_req;
      end
      if (state == ST_CLEAR) begin
        os_sel_q <= pend;
      end
    end
  end

  assign os_sel   = os_sel_q;
  assign filt_clr = (state == ST_CLEAR);
  assign busy     = (state != ST_RUN);
`ifdef CIC_RATE_CTRL_SETTLE_EN
  assign out_valid = clk_div && (state != ST_SETTLE);
`else
  assign out_valid = clk_div;
`endif

endmodule

// File: tb/tb_cic_rate_ctrl.sv
// Directed bench for cic_rate_ctrl: rate changes, drain/clear timing, settle discard, reset mid-change.
module tb_cic_rate_ctrl;

`ifdef CIC_RATE_CTRL_SETTLE_EN
  localparam int SET_N = 3;
`else
  localparam int SET_N = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [2:0] os_sel_req;
  logic       os_sel_wr;
  logic [2:0] os_sel;
  logic       clk_div;
  logic       filt_clr;
  logic       out_valid;
  logic       busy;

  int         vecs = 0;
  int         miscompares = 0;
  logic       sb;
  logic [5:0] ivp = 6'b001101;

  always #5 clk = ~clk;

  cic_rate_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .os_sel_req (os_sel_req),
    .os_sel_wr  (os_sel_wr),
    .os_sel     (os_sel),
    .clk_div    (clk_div),
    .filt_clr   (filt_clr),
    .out_valid  (out_valid),
    .busy       (busy)
  );

  function automatic logic [6:0] ex(input logic [2:0] os, input logic c, input logic ov,
                                    input logic f, input logic b);
    return {os, c, ov, f, b};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {os_sel, clk_div, out_valid, filt_clr, busy};
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed os_sel/clk_div/out_valid/filt_clr/busy=%b required %b", tag, obs, exp);
    end
  endtask

  // Continuous in_valid at period p; the first s strobes are settle discards.
  task automatic run_stream(input int p, input int n, input int s, input logic [2:0] os,
                            input int wr_at, input string tag);
    logic c;
    logic b;
    for (int k = 1; k <= n; k++) begin
      os_sel_wr  = (k == wr_at);
      os_sel_req = 3'd5;
      tick;
      os_sel_wr = 1'b0;
      c = ((k % p) == 0);
      b = (k <= p * s);
      chk(tag, ex(os, c, c && (k > p * s), 1'b0, b));
    end
  endtask

  initial begin
    sb         = (SET_N > 0);
    reset      = 1'b1;
    in_valid   = 1'b0;
    os_sel_wr  = 1'b0;
    os_sel_req = 3'd0;

    tick;
    chk("reset", ex(3'd1, 0, 0, 0, 0));
    tick;
    chk("reset_hold", ex(3'd1, 0, 0, 0, 0));
    reset = 1'b0;

    // os_sel=1: strobe every second sample, first one after the second in_valid
    in_valid = 1'b1;
    run_stream(2, 6, 0, 3'd1, 0, "run_os1");

    // mid-frame write of 3
    os_sel_wr  = 1'b1;
    os_sel_req = 3'd3;
    tick;
    os_sel_wr = 1'b0;
    chk("wr_mid", ex(3'd1, 0, 0, 0, 1));
    tick;
    chk("drain_term", ex(3'd1, 1, 1, 0, 1));
    tick;
    chk("clear", ex(3'd1, 0, 0, 1, 1));
    tick;
    chk("new_sel3", ex(3'd3, 0, 0, 0, sb));
    run_stream(8, 32, SET_N, 3'd3, (SET_N > 0) ? 12 : 0, "settle8");

    // write coincident with a terminal count
    run_stream(8, 7, 0, 3'd3, 0, "pre_coinc");
    os_sel_wr  = 1'b1;
    os_sel_req = 3'd1;
    tick;
    os_sel_wr = 1'b0;
    chk("coinc", ex(3'd3, 1, 1, 0, 1));
    tick;
    chk("coinc_clr", ex(3'd3, 0, 0, 1, 1));
    tick;
    chk("coinc_sel1", ex(3'd1, 0, 0, 0, sb));
    run_stream(2, 8, SET_N, 3'd1, 0, "settle2");

    // two writes in DRAIN, last one (0) wins
    os_sel_wr  = 1'b1;
    os_sel_req = 3'd2;
    tick;
    chk("dr_wr1", ex(3'd1, 0, 0, 0, 1));
    os_sel_req = 3'd0;
    tick;
    os_sel_wr = 1'b0;
    chk("dr_wr2", ex(3'd1, 1, 1, 0, 1));
    tick;
    chk("dr_clr", ex(3'd1, 0, 0, 1, 1));
    tick;
    chk("dr_sel0", ex(3'd0, 0, 0, 0, sb));
    run_stream(1, 6, SET_N, 3'd0, 0, "settle1");

    // os_sel=0 with gaps: clk_div mirrors in_valid one cycle later
    for (int j = 0; j < 6; j++) begin
      in_valid = ivp[j];
      tick;
      chk("gap_os0", ex(3'd0, ivp[j], ivp[j], 0, 0));
    end

    // reset during the change to 2
    in_valid   = 1'b1;
    os_sel_wr  = 1'b1;
    os_sel_req = 3'd2;
    tick;
    os_sel_wr = 1'b0;
    chk("f_coinc", ex(3'd0, 1, 1, 0, 1));
    tick;
    chk("f_clr", ex(3'd0, 0, 0, 1, 1));
    tick;
    chk("f_sel2", ex(3'd2, 0, 0, 0, sb));
    tick;
    tick;
    chk("f_k2", ex(3'd2, 0, 0, 0, sb));
    reset = 1'b1;
    tick;
    chk("rst_mid", ex(3'd1, 0, 0, 0, 0));
    reset = 1'b0;
    run_stream(2, 4, 0, 3'd1, 0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
